// File: rtl/sub_serial_seq_if.sv
// Operand/result handshake bundle for sub_serial_seq: operands in on in_valid/in_ready,
// difference and flags out on out_valid/out_ready.
interface sub_serial_seq_if #(parameter int BYTES = 4) ();
    localparam int W = 8 * BYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf, zero
    );
endinterface

// File: rtl/sub_serial_seq.sv
// Byte-serial a-b through one 8-bit subtract slice; result BYTES cycles after accept.
// No overlap: in_ready only in IDLE, DONE holds the result until out_ready.
module sub_serial_seq #(
    parameter int BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    sub_serial_seq_if.slave   bus
);
    localparam int W = 8 * BYTES;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic         carry_q, carry_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] diff_q, diff_d;
    logic         borrow_q, borrow_d;
    logic         ovf_q, ovf_d;
    logic         zero_q, zero_d;

    logic [7:0]   a_byte, b_byte;
    logic [8:0]   sum;
    logic         last;
    logic [W-1:0] diff_wr;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        // Subtraction as a + ~b + 1, the +1 entering as the initial carry.
        a_byte  = a_q[8*int'(idx_q) +: 8];
        b_byte  = b_q[8*int'(idx_q) +: 8];
        sum     = {1'b0, a_byte} + {1'b0, ~b_byte} + {8'd0, carry_q};
        last    = (idx_q == 3'(BYTES - 1));
        diff_wr = diff_q;
        diff_wr[8*int'(idx_q) +: 8] = sum[7:0];

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = '0;
                    carry_d = 1'b1;
                    diff_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d  = diff_wr;
                carry_d = sum[8];
                idx_d   = idx_q + 3'd1;
                if (last) begin
                    // Flags use the full difference including the byte written now.
                    borrow_d = ~sum[8];
                    ovf_d    = (a_q[W-1] != b_q[W-1]) & (diff_wr[W-1] != a_q[W-1]);
                    zero_d   = ~|diff_wr;
                    idx_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_sub_serial_seq.sv
// Scoreboard bench for sub_serial_seq at BYTES=4 and BYTES=1 with directed vectors.
module tb_sub_serial_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sub_serial_seq_if #(.BYTES(4)) ifc4 ();
    sub_serial_seq_if #(.BYTES(1)) ifc1 ();

    sub_serial_seq #(.BYTES(4)) dut4 (.clk(clk), .rst(rst), .bus(ifc4.slave));
    sub_serial_seq #(.BYTES(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.slave));

    typedef struct {
        logic [31:0] d;
        logic        br;
        logic        ov;
        logic        z;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic        br;
        logic        ov;
        logic        z;
    } vec_t;

    exp_t q4[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic ov4_prev = 1'b0;
    logic ov1_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result monitors: check every DONE cycle (stability under back-pressure), pop on consume.
    always @(negedge clk) begin
        if (ifc4.out_valid === 1'b1) begin
            if (q4.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out4: got diff %h expected no result", ifc4.diff);
            end else begin
                if (!ov4_prev) chk("latency4", cyc - q4[0].acc, 32'd4);
                chk("diff4", ifc4.diff, q4[0].d);
                chk("borrow4", {31'd0, ifc4.borrow}, {31'd0, q4[0].br});
                chk("ovf4", {31'd0, ifc4.ovf}, {31'd0, q4[0].ov});
                chk("zero4", {31'd0, ifc4.zero}, {31'd0, q4[0].z});
                chk("in_ready_done4", {31'd0, ifc4.in_ready}, 32'd0);
                if (ifc4.out_ready) void'(q4.pop_front());
            end
        end
        ov4_prev = ifc4.out_valid;
    end

    always @(negedge clk) begin
        if (ifc1.out_valid === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out1: got diff %h expected no result", ifc1.diff);
            end else begin
                if (!ov1_prev) chk("latency1", cyc - q1[0].acc, 32'd1);
                chk("diff1", {24'd0, ifc1.diff}, q1[0].d);
                chk("borrow1", {31'd0, ifc1.borrow}, {31'd0, q1[0].br});
                chk("ovf1", {31'd0, ifc1.ovf}, {31'd0, q1[0].ov});
                chk("zero1", {31'd0, ifc1.zero}, {31'd0, q1[0].z});
                if (ifc1.out_ready) void'(q1.pop_front());
            end
        end
        ov1_prev = ifc1.out_valid;
    end

    task automatic send4(input vec_t v, input bit push);
        int n = 0;
        ifc4.in_valid = 1'b1;
        ifc4.a = v.a;
        ifc4.b = v.b;
        while (ifc4.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (ifc4.in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout4: in_ready %b expected 1", ifc4.in_ready);
        end
        @(posedge clk); #1;
        if (push) q4.push_back('{v.d, v.br, v.ov, v.z, cyc});
        ifc4.in_valid = 1'b0;
        ifc4.a = $urandom;
        ifc4.b = $urandom;
    endtask

    task automatic send1(input vec_t v);
        int n = 0;
        ifc1.in_valid = 1'b1;
        ifc1.a = v.a[7:0];
        ifc1.b = v.b[7:0];
        while (ifc1.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (ifc1.in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout1: in_ready %b expected 1", ifc1.in_ready);
        end
        @(posedge clk); #1;
        q1.push_back('{v.d, v.br, v.ov, v.z, cyc});
        ifc1.in_valid = 1'b0;
        ifc1.a = 8'($urandom);
        ifc1.b = 8'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (q4.size() != 0 || q1.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending %0d/%0d expected 0/0", q4.size(), q1.size());
        end
    endtask

    vec_t v4[6] = '{
        '{32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 1'b0, 1'b0},
        '{32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b0, 1'b0},
        '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0},
        '{32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0},
        '{32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 1'b1},
        '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0}
    };

    vec_t v1[4] = '{
        '{32'h80, 32'h01, 32'h7F, 1'b0, 1'b1, 1'b0},
        '{32'h00, 32'h01, 32'hFF, 1'b1, 1'b0, 1'b0},
        '{32'h05, 32'h05, 32'h00, 1'b0, 1'b0, 1'b1},
        '{32'h7F, 32'hFF, 32'h80, 1'b1, 1'b1, 1'b0}
    };

    initial begin
        int n;
        ifc4.in_valid = 1'b0; ifc4.a = '0; ifc4.b = '0; ifc4.out_ready = 1'b1;
        ifc1.in_valid = 1'b0; ifc1.a = '0; ifc1.b = '0; ifc1.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready4", {31'd0, ifc4.in_ready}, 32'd1);
        chk("rst_out_valid4", {31'd0, ifc4.out_valid}, 32'd0);
        chk("rst_diff4", ifc4.diff, 32'd0);
        chk("rst_flags4", {29'd0, ifc4.borrow, ifc4.ovf, ifc4.zero}, 32'd0);
        chk("rst_in_ready1", {31'd0, ifc1.in_ready}, 32'd1);
        chk("rst_out_valid1", {31'd0, ifc1.out_valid}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (v4[i]) send4(v4[i], 1'b1);
        wait_drain();

        // Back-pressure: result must hold while new operands are offered and refused.
        ifc4.out_ready = 1'b0;
        send4('{32'h20, 32'h08, 32'h18, 1'b0, 1'b0, 1'b0}, 1'b1);
        n = 0;
        while (ifc4.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_out_valid", {31'd0, ifc4.out_valid}, 32'd1);
        repeat (3) begin
            ifc4.in_valid = 1'b1; ifc4.a = 32'h0000DEAD; ifc4.b = 32'h1;
            @(posedge clk); #1;
        end
        ifc4.in_valid = 1'b0;
        ifc4.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after", {31'd0, ifc4.in_ready}, 32'd1);
        chk("bp_out_valid_after", {31'd0, ifc4.out_valid}, 32'd0);
        repeat (6) @(posedge clk);
        #1;

        // Reset on the second RUN edge aborts the operation without any output.
        send4('{32'h11111111, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0}, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", {31'd0, ifc4.out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, ifc4.in_ready}, 32'd1);
        chk("abort_diff", ifc4.diff, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        send4('{32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0}, 1'b1);
        wait_drain();

        foreach (v1[i]) send1(v1[i]);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
